// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side UART controller. Runs on a clock at OVERSAMPLE x baud,
// qualifies the start bit at its midpoint, samples each data bit once per
// bit period (LSB first), checks a single stop bit and hands the byte to the
// consumer over a valid/ready handshake.
//
// Parameters
//   OVERSAMPLE : clocks per bit (even, >= 4)
//   DATA_BITS  : data bits per frame (no parity, one stop bit)
//
// Ports
//   clk       : sampling clock (OVERSAMPLE x baud)
//   rst       : synchronous, active-high reset
//   rx        : asynchronous serial input, idles high
//   rd_ready  : consumer accepts rx_data this cycle
//   rx_data   : received byte, stable while rx_valid = 1
//   rx_valid  : byte available, held until accepted
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a good frame is dropped because the
//               previous byte is still pending and not being accepted
//   busy      : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Registered state
  logic                 sync1_q, sync2_q;
  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 busy_q;

  // Next-state values
  logic                 sync1_d, sync2_d;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [IDX_W-1:0]     idx_d;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d;
  logic                 frame_err_d;
  logic                 overrun_d;
  logic                 busy_d;

  logic                 rx_s;
  logic                 cnt_last;
  logic                 good_stop;

  assign rx_s     = sync2_q;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    good_stop   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Re-check the line at the middle of the start bit; a glitch that
        // has already returned high is treated as a false start.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) begin
          // LSB-first: each new bit enters at the MSB and moves down.
          shift_d                = shift_q >> 1;
          shift_d[DATA_BITS-1]   = rx_s;
          idx_d                  = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        if (cnt_last) begin
          if (rx_s) begin
            good_stop = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Hold off until the line returns high so a stuck-low line does not
        // generate a stream of bogus frames.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Consumer handshake; a load in the same cycle overrides the clear.
    if (rx_valid_q && rd_ready) begin
      rx_valid_d = 1'b0;
    end

    if (good_stop) begin
      if (!rx_valid_q || rd_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed testbench for uart_rx_ctrl at default parameters. Inputs change on
// the falling clock edge and outputs are sampled on the falling edge. A frame
// driven from negedge N0 has its stop bit sampled at the 79th rising edge, so
// its result is visible at negedge N79. Bytes expected to be delivered are
// pushed to a queue when sent and popped when the DUT loads them.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int OS = 8;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          rd_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_data;

  uart_rx_ctrl #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_ready (rd_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive ncyc clocks of a frame (start, data LSB first, stop) starting at
  // the current negedge; returns at negedge N<ncyc> with rx still driven.
  task automatic send_cycles(input logic [7:0] data, input logic stop_bit, input int ncyc);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      rx = frame[c / OS];
      @(negedge clk);
    end
  endtask

  // Called at N79 of a frame that should load a byte.
  task automatic expect_load(input string tag);
    check({tag, "_valid"}, rx_valid, 1'b1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb: observed load expected empty scoreboard", tag);
    end else begin
      exp_data = exp_q.pop_front();
      check({tag, "_data"}, rx_data, exp_data);
    end
  endtask

  task automatic accept(input string tag);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check({tag, "_cleared"}, rx_valid, 1'b0);
  endtask

  initial begin
    logic seen_valid, seen_ferr, seen_ovr, all_busy;

    // ---------------- Reset ----------------
    rst      = 1'b1;
    rx       = 1'b1;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---------------- Clean frame 0x5A ----------------
    exp_q.push_back(8'h5A);
    send_cycles(8'h5A, 1'b1, 78);
    check("clean_pre_valid", rx_valid, 1'b0);
    check("clean_busy", busy, 1'b1);
    @(negedge clk);
    expect_load("clean");
    check("clean_idle", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("clean_hold_valid", rx_valid, 1'b1);
    check("clean_hold_data", rx_data, exp_data);
    accept("clean");

    // ---------------- False start ----------------
    repeat (4) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    seen_valid = 1'b0;
    seen_ferr  = 1'b0;
    seen_ovr   = 1'b0;
    @(negedge clk);
    check("fs_busy_rise", busy, 1'b1);
    for (int i = 3; i < 14; i++) begin
      if (i == 7) check("fs_busy_fall", busy, 1'b0);
      seen_valid |= rx_valid;
      seen_ferr  |= frame_err;
      seen_ovr   |= overrun;
      @(negedge clk);
    end
    check("fs_no_valid", seen_valid, 1'b0);
    check("fs_no_ferr", seen_ferr, 1'b0);
    check("fs_no_ovr", seen_ovr, 1'b0);

    // ---------------- Framing error 0xC3 ----------------
    send_cycles(8'hC3, 1'b0, 78);
    check("fe_pre", frame_err, 1'b0);
    @(negedge clk);
    check("fe_pulse", frame_err, 1'b1);
    check("fe_no_valid", rx_valid, 1'b0);
    check("fe_busy", busy, 1'b1);
    seen_ferr = 1'b0;
    all_busy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen_ferr |= frame_err;
      all_busy  &= busy;
    end
    check("fe_single_pulse", seen_ferr, 1'b0);
    check("fe_break_held", all_busy, 1'b1);
    check("fe_break_no_valid", rx_valid, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("fe_break_exit", busy, 1'b0);
    repeat (4) @(negedge clk);

    // ---------------- Overrun ----------------
    exp_q.push_back(8'h11);
    send_cycles(8'h11, 1'b1, 78);
    @(negedge clk);
    expect_load("ovr_first");
    @(negedge clk);
    send_cycles(8'h22, 1'b1, 78);   // not pushed: must be dropped
    check("ovr_pre", overrun, 1'b0);
    @(negedge clk);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_no_ferr", frame_err, 1'b0);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data_kept", rx_data, exp_data);
    @(negedge clk);
    check("ovr_one_cycle", overrun, 1'b0);
    accept("ovr");
    repeat (4) @(negedge clk);

    // ---------------- Back-to-back with simultaneous accept ----------------
    exp_q.push_back(8'h11);
    send_cycles(8'h11, 1'b1, 78);
    @(negedge clk);
    expect_load("b2b_first");
    @(negedge clk);
    exp_q.push_back(8'h22);
    send_cycles(8'h22, 1'b1, 78);
    check("b2b_pre_valid", rx_valid, 1'b1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    expect_load("b2b_second");
    check("b2b_no_ovr", overrun, 1'b0);
    @(negedge clk);
    check("b2b_still_valid", rx_valid, 1'b1);
    check("b2b_no_ovr_late", overrun, 1'b0);

    // ---------------- Reset mid-frame (0x22 left pending) ----------------
    send_cycles(8'hFF, 1'b1, 35);   // inside data bit 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    seen_ferr = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seen_ferr  |= frame_err;
      seen_valid |= rx_valid;
    end
    check("mid_rst_quiet_ferr", seen_ferr, 1'b0);
    check("mid_rst_quiet_valid", seen_valid, 1'b0);
    exp_q.push_back(8'h81);
    send_cycles(8'h81, 1'b1, 78);
    @(negedge clk);
    expect_load("after_rst");
    accept("after_rst");

    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
